// File: rtl/sisc_rst_seq.sv
`timescale 1ns/1ps
// sisc_rst_seq
// Clock-domain reset sequencer and run monitor for the SISC core.
// - Synchronises the asynchronous active-low rst_f (release edge only).
// - Holds reset HOLD_CYCLES cycles, then releases NUM_CH channels,
//   channel 0 first, STAGGER cycles apart, then enters RUN.
// - Reports run/halted status and a saturating RUN-cycle counter.
// Optional feature: define SISC_RST_WDOG_EN to enable the watchdog, which
// forces all channels back into reset (TIMEOUT) when cycle_cnt reaches
// WDOG_LIMIT. Without it, timeout is tied low and cycle_cnt saturates at
// all-ones.
module sisc_rst_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned STAGGER     = 2,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned WDOG_LIMIT  = 1000
) (
    input  logic                 clk,
    input  logic                 rst_f,
    input  logic                 sw_rst_req,
    input  logic                 halt,
    output logic [NUM_CH-1:0]    rst_out_f,
    output logic                 run,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic                 timeout
);

    // Counter widths: hold and stagger count 0..N-1, channel index 0..NUM_CH.
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned STG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_CH + 1);

    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STG_W-1:0]     STG_LAST  = STG_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]     IDX_DONE  = IDX_W'(NUM_CH);
    localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
    localparam logic [STG_W-1:0]     STG_ONE   = STG_W'(1);
    localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    // Reject parameter sets the sequencer cannot honour.
    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || NUM_CH < 1 || NUM_CH > 8 ||
        STAGGER < 1 || CNT_WIDTH < 1 || WDOG_LIMIT < 1 ||
        $clog2(WDOG_LIMIT + 1) > CNT_WIDTH) begin : g_bad_params
        $error("sisc_rst_seq: illegal parameter combination");
    end

`ifdef SISC_RST_WDOG_EN
    localparam logic [CNT_WIDTH-1:0] WDOG_MAX = CNT_WIDTH'(WDOG_LIMIT);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RELEASE,
        ST_RUN,
        ST_HALTED
    } state_e;
`endif

    // Reset synchroniser
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rst_sync;

    // Sequencer state
    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STG_W-1:0]       stg_cnt_q, stg_cnt_d;
    logic [IDX_W-1:0]       ch_idx_q, ch_idx_d;
    logic [NUM_CH-1:0]      rst_out_q, rst_out_d;
    logic                   run_q, run_d;
    logic                   halted_q, halted_d;
    logic [CNT_WIDTH-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic                   restart;
`ifdef SISC_RST_WDOG_EN
    logic                   timeout_q, timeout_d;
`endif

    // Synchroniser next state: shift a 1 in from the bottom each edge.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Synchroniser flops: cleared immediately on rst_f, released through the chain.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    // Sequencer next-state: restart condition first, then per-state behaviour.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        stg_cnt_d   = stg_cnt_q;
        ch_idx_d    = ch_idx_q;
        rst_out_d   = rst_out_q;
        run_d       = run_q;
        halted_d    = halted_q;
        cycle_cnt_d = cycle_cnt_q;
`ifdef SISC_RST_WDOG_EN
        timeout_d   = timeout_q;
`endif
        cnt_inc     = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;

        // While the synchroniser is still low everything is held at its reset
        // value (sw_rst_req then has no extra effect); once it is high, a soft
        // request pulls the sequencer back to the start of HOLD.
        restart = !rst_sync || sw_rst_req;

        if (restart) begin
            state_d     = ST_HOLD;
            hold_cnt_d  = '0;
            stg_cnt_d   = '0;
            ch_idx_d    = '0;
            rst_out_d   = '0;
            run_d       = 1'b0;
            halted_d    = 1'b0;
            cycle_cnt_d = '0;
`ifdef SISC_RST_WDOG_EN
            timeout_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d      = ST_RELEASE;
                        hold_cnt_d   = '0;
                        stg_cnt_d    = '0;
                        rst_out_d[0] = 1'b1;
                        ch_idx_d     = IDX_ONE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end

                ST_RELEASE: begin
                    if (ch_idx_q == IDX_DONE) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                    end else if (stg_cnt_q == STG_LAST) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            if (ch_idx_q == IDX_W'(i)) begin
                                rst_out_d[i] = 1'b1;
                            end
                        end
                        ch_idx_d  = ch_idx_q + IDX_ONE;
                        stg_cnt_d = '0;
                    end else begin
                        stg_cnt_d = stg_cnt_q + STG_ONE;
                    end
                end

                ST_RUN: begin
                    // The halting edge still counts as a RUN cycle.
                    cycle_cnt_d = cnt_inc;
                    if (halt) begin
                        state_d  = ST_HALTED;
                        run_d    = 1'b0;
                        halted_d = 1'b1;
                    end
`ifdef SISC_RST_WDOG_EN
                    else if (cnt_inc == WDOG_MAX) begin
                        state_d   = ST_TIMEOUT;
                        run_d     = 1'b0;
                        rst_out_d = '0;
                        timeout_d = 1'b1;
                    end
`endif
                end

                ST_HALTED: begin
                    state_d = ST_HALTED;
                end

`ifdef SISC_RST_WDOG_EN
                ST_TIMEOUT: begin
                    state_d = ST_TIMEOUT;
                end
`endif

                default: begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    stg_cnt_d   = '0;
                    ch_idx_d    = '0;
                    rst_out_d   = '0;
                    run_d       = 1'b0;
                    halted_d    = 1'b0;
                    cycle_cnt_d = '0;
                end
            endcase
        end
    end

    // Sequencer registers: all outputs come straight from these flops.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            stg_cnt_q   <= '0;
            ch_idx_q    <= '0;
            rst_out_q   <= '0;
            run_q       <= 1'b0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
`ifdef SISC_RST_WDOG_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stg_cnt_q   <= stg_cnt_d;
            ch_idx_q    <= ch_idx_d;
            rst_out_q   <= rst_out_d;
            run_q       <= run_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
`ifdef SISC_RST_WDOG_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign rst_out_f = rst_out_q;
    assign run       = run_q;
    assign halted    = halted_q;
    assign cycle_cnt = cycle_cnt_q;
`ifdef SISC_RST_WDOG_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_rst_seq.sv
`timescale 1ns/1ps
// tb_sisc_rst_seq: directed bench for sisc_rst_seq.
// u_dut uses default parameters; u_sat (CNT_WIDTH=4, WDOG_LIMIT=10) and
// u_wd (WDOG_LIMIT=50) cover counter saturation and the watchdog, with
// expectations selected by SISC_RST_WDOG_EN.
module tb_sisc_rst_seq;

`ifdef SISC_RST_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk;
    logic        rst_f, sw_rst_req, halt;
    logic [2:0]  rst_out_f;
    logic        run, halted, timeout;
    logic [15:0] cycle_cnt;

    logic        rst_aux_f, sw_aux, halt_aux;
    logic [2:0]  sat_rst_out, wd_rst_out;
    logic        sat_run, sat_halted, sat_timeout;
    logic        wd_run, wd_halted, wd_timeout;
    logic [3:0]  sat_cnt;
    logic [15:0] wd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sisc_rst_seq u_dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .sw_rst_req (sw_rst_req),
        .halt       (halt),
        .rst_out_f  (rst_out_f),
        .run        (run),
        .halted     (halted),
        .cycle_cnt  (cycle_cnt),
        .timeout    (timeout)
    );

    sisc_rst_seq #(.CNT_WIDTH(4), .WDOG_LIMIT(10)) u_sat (
        .clk        (clk),
        .rst_f      (rst_aux_f),
        .sw_rst_req (sw_aux),
        .halt       (halt_aux),
        .rst_out_f  (sat_rst_out),
        .run        (sat_run),
        .halted     (sat_halted),
        .cycle_cnt  (sat_cnt),
        .timeout    (sat_timeout)
    );

    sisc_rst_seq #(.WDOG_LIMIT(50)) u_wd (
        .clk        (clk),
        .rst_f      (rst_aux_f),
        .sw_rst_req (sw_aux),
        .halt       (halt_aux),
        .rst_out_f  (wd_rst_out),
        .run        (wd_run),
        .halted     (wd_halted),
        .cycle_cnt  (wd_cnt),
        .timeout    (wd_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Channel mask n edges after the reference edge, with ch0 due at base
    // and each further channel 2 edges later.
    function automatic logic [2:0] exp_ch(input int n, input int base);
        logic [2:0] m;
        m = '0;
        for (int k = 0; k < 3; k++) begin
            if (n >= base + 2 * k) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    initial begin
        rst_f      = 1'b1;
        rst_aux_f  = 1'b1;
        sw_rst_req = 1'b0;
        halt       = 1'b0;
        sw_aux     = 1'b0;
        halt_aux   = 1'b0;
        #1;
        rst_f     = 1'b0;
        rst_aux_f = 1'b0;
        #1;
        // Reset values, no clock edge seen yet.
        check("rst rst_out_f", rst_out_f, 0);
        check("rst run", run, 0);
        check("rst halted", halted, 0);
        check("rst cycle_cnt", cycle_cnt, 0);
        check("rst timeout", timeout, 0);
        check("rst sat_rst_out", sat_rst_out, 0);

        // Power-up release: E0 is the first posedge after rst_f rises.
        @(negedge clk);
        @(negedge clk);
        rst_f = 1'b1;
        for (int n = 0; n <= 30; n++) begin
            @(negedge clk);
            if (n <= 11) begin
                check($sformatf("pwr rst_out_f E0+%0d", n), rst_out_f, exp_ch(n, 5));
                check($sformatf("pwr run E0+%0d", n), run, (n >= 10) ? 1 : 0);
            end
            if (n == 11) check("pwr cycle_cnt E0+11", cycle_cnt, 1);
            if (n == 15) check("pwr cycle_cnt E0+15", cycle_cnt, 5);
        end
        check("halt pre cycle_cnt", cycle_cnt, 20);

        // Halt while cycle_cnt = 20.
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        check("halt run", run, 0);
        check("halt halted", halted, 1);
        check("halt cycle_cnt", cycle_cnt, 21);
        check("halt rst_out_f", rst_out_f, 3'b111);
        repeat (3) @(negedge clk);
        check("halted cycle_cnt frozen", cycle_cnt, 21);
        check("halted stays", halted, 1);

        // Soft reset out of HALTED; release repeats with no synchroniser delay.
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("sw rst_out_f", rst_out_f, 0);
        check("sw halted", halted, 0);
        check("sw run", run, 0);
        check("sw cycle_cnt", cycle_cnt, 0);
        for (int m = 1; m <= 5; m++) begin
            @(negedge clk);
            check($sformatf("sw rst_out_f S+%0d", m), rst_out_f, exp_ch(m, 4));
        end

        // Asynchronous reset between edges while in RELEASE.
        #2;
        rst_f = 1'b0;
        #1;
        check("async rst_out_f", rst_out_f, 0);
        check("async run", run, 0);
        check("async halted", halted, 0);
        check("async cycle_cnt", cycle_cnt, 0);
        check("async timeout", timeout, 0);
        @(negedge clk);
        check("async held rst_out_f", rst_out_f, 0);

        // Restart; sw_rst_req over E0 and E0+1 must be ignored (rst_sync low).
        rst_f      = 1'b1;
        sw_rst_req = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) sw_rst_req = 1'b0;
            check($sformatf("re rst_out_f E0+%0d", n), rst_out_f, exp_ch(n, 5));
            check($sformatf("re run E0+%0d", n), run, (n >= 10) ? 1 : 0);
        end
        check("re cycle_cnt", cycle_cnt, 2);

        // sw_rst_req and halt together: HOLD wins.
        sw_rst_req = 1'b1;
        halt       = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        halt       = 1'b0;
        check("swhalt rst_out_f", rst_out_f, 0);
        check("swhalt cycle_cnt", cycle_cnt, 0);
        check("swhalt halted", halted, 0);
        check("swhalt run", run, 0);
        // Second request sampled at S+2 restarts the hold count: ch0 at S+6.
        @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        for (int m = 3; m <= 7; m++) begin
            @(negedge clk);
            check($sformatf("swhold rst_out_f S+%0d", m), rst_out_f, exp_ch(m, 6));
        end
        check("main timeout", timeout, 0);

        // Saturation / watchdog instances.
        @(negedge clk);
        rst_aux_f = 1'b1;
        for (int n = 0; n <= 66; n++) begin
            @(negedge clk);
            check($sformatf("sat cnt E0+%0d", n), sat_cnt,
                  (n <= 10) ? 0 : min_i(n - 10, WD ? 10 : 15));
            check($sformatf("sat timeout E0+%0d", n), sat_timeout, (WD && n >= 20) ? 1 : 0);
            check($sformatf("sat run E0+%0d", n), sat_run,
                  (n >= 10 && !(WD && n >= 20)) ? 1 : 0);
            check($sformatf("sat rst_out E0+%0d", n), sat_rst_out,
                  (WD && n >= 20) ? 0 : exp_ch(n, 5));
            check($sformatf("wd cnt E0+%0d", n), wd_cnt,
                  (n <= 10) ? 0 : (WD ? min_i(n - 10, 50) : n - 10));
            check($sformatf("wd timeout E0+%0d", n), wd_timeout, (WD && n >= 60) ? 1 : 0);
            check($sformatf("wd run E0+%0d", n), wd_run,
                  (n >= 10 && !(WD && n >= 60)) ? 1 : 0);
            check($sformatf("wd rst_out E0+%0d", n), wd_rst_out,
                  (WD && n >= 60) ? 0 : exp_ch(n, 5));
        end
        check("sat halted", sat_halted, 0);
        check("wd halted", wd_halted, 0);

        // Soft reset clears timeout and the counter.
        sw_aux = 1'b1;
        @(negedge clk);
        sw_aux = 1'b0;
        check("wdclr timeout", wd_timeout, 0);
        check("wdclr cnt", wd_cnt, 0);
        check("wdclr rst_out", wd_rst_out, 0);
        check("wdclr run", wd_run, 0);
        check("satclr timeout", sat_timeout, 0);
        check("satclr cnt", sat_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
